// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

  localparam int unsigned NB_DATA        = 32;
  localparam int unsigned NB_LANE        = 8;
  localparam int unsigned N_LANES        = NB_DATA / NB_LANE;
  localparam int unsigned RAM_DEPTH      = 512;
  localparam int unsigned NB_WADDR       = $clog2(RAM_DEPTH);
  localparam int unsigned NB_BADDR       = NB_WADDR + 2;
  localparam int unsigned DBG_STARVE_MAX = 4;
  localparam int unsigned NB_STARVE      = $clog2(DBG_STARVE_MAX + 1);

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DATA   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Request fields kept from grant until response.
  typedef struct packed {
    logic       dbg;
    logic       we;
    size_e      size;
    logic       uns;
    logic [1:0] off;
  } req_t;

  // Misaligned half/word or illegal size.
  function automatic logic access_err(size_e size, logic [1:0] off);
    case (size)
      SIZE_B:  access_err = 1'b0;
      SIZE_H:  access_err = off[0];
      SIZE_W:  access_err = (off != 2'b00);
      default: access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_controller_if.sv
// CPU, debug and BRAM bus signals of the data-memory controller.
interface dmem_controller_if;
  import dmem_pkg::*;

  logic                i_cpu_req;
  logic                i_cpu_we;
  logic [1:0]          i_cpu_size;
  logic                i_cpu_unsigned;
  logic [NB_BADDR-1:0] i_cpu_addr;
  logic [NB_DATA-1:0]  i_cpu_wdata;
  logic [NB_DATA-1:0]  o_cpu_rdata;
  logic                o_cpu_ack;
  logic                o_cpu_err;

  logic                i_dbg_req;
  logic                i_dbg_we;
  logic [NB_WADDR-1:0] i_dbg_addr;
  logic [NB_DATA-1:0]  i_dbg_wdata;
  logic [NB_DATA-1:0]  o_dbg_rdata;
  logic                o_dbg_ack;

  logic [NB_WADDR-1:0] o_ram_waddr;
  logic [NB_WADDR-1:0] o_ram_raddr;
  logic [NB_DATA-1:0]  o_ram_din;
  logic [N_LANES-1:0]  o_ram_wen;
  logic                o_ram_ren;
  logic [NB_DATA-1:0]  i_ram_dout;

  // Controller side.
  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_size, i_cpu_unsigned, i_cpu_addr, i_cpu_wdata,
    output o_cpu_rdata, o_cpu_ack, o_cpu_err,
    input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    output o_dbg_rdata, o_dbg_ack,
    output o_ram_waddr, o_ram_raddr, o_ram_din, o_ram_wen, o_ram_ren,
    input  i_ram_dout
  );

  // Requester / memory side.
  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_size, i_cpu_unsigned, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_rdata, o_cpu_ack, o_cpu_err,
    output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    input  o_dbg_rdata, o_dbg_ack,
    input  o_ram_waddr, o_ram_raddr, o_ram_din, o_ram_wen, o_ram_ren,
    output i_ram_dout
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane store formatter and load extractor/extender (combinational).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e              i_st_size,
  input  logic [1:0]         i_st_off,
  input  logic [NB_DATA-1:0] i_st_wdata,
  output logic [N_LANES-1:0] o_wen_c,
  output logic [NB_DATA-1:0] o_din_c,
  input  size_e              i_ld_size,
  input  logic [1:0]         i_ld_off,
  input  logic               i_ld_uns,
  input  logic [NB_DATA-1:0] i_ld_dout,
  output logic [NB_DATA-1:0] o_rdata_c
);

  logic [15:0] ld_lo16;

  // Replicate store data across lanes and select the written lanes.
  always_comb begin
    o_wen_c = '0;
    o_din_c = i_st_wdata;
    case (i_st_size)
      SIZE_B: begin
        o_wen_c = N_LANES'(1) << i_st_off;
        o_din_c = {N_LANES{i_st_wdata[7:0]}};
      end
      SIZE_H: begin
        o_wen_c = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_din_c = {2{i_st_wdata[15:0]}};
      end
      SIZE_W:  o_wen_c = '1;
      default: o_wen_c = '0;
    endcase
  end

  // Right-align the addressed lane(s) and sign- or zero-extend.
  always_comb begin
    ld_lo16   = 16'(i_ld_dout >> {i_ld_off, 3'b000});
    o_rdata_c = i_ld_dout;
    case (i_ld_size)
      SIZE_B:  o_rdata_c = i_ld_uns ? {24'h0, ld_lo16[7:0]}
                                    : {{24{ld_lo16[7]}}, ld_lo16[7:0]};
      SIZE_H:  o_rdata_c = i_ld_uns ? {16'h0, ld_lo16}
                                    : {{16{ld_lo16[15]}}, ld_lo16};
      default: o_rdata_c = i_ld_dout;
    endcase
  end

endmodule

// File: rtl/dmem_controller.sv
// CPU/debug arbiter and access sequencer in front of a byte-enable BRAM.
module dmem_controller
  import dmem_pkg::*;
(
  input logic              i_clk,
  input logic              i_rst,
  dmem_controller_if.slave bus
);

  state_e               state_q, state_d;
  logic [NB_STARVE-1:0] starve_q, starve_d;
  req_t                 req_q, req_d;

  logic [NB_DATA-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                cpu_err_q, cpu_err_d;
  logic [NB_DATA-1:0]  dbg_rdata_q, dbg_rdata_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic [NB_WADDR-1:0] ram_addr_q, ram_addr_d;
  logic [NB_DATA-1:0]  ram_din_q, ram_din_d;
  logic [N_LANES-1:0]  ram_wen_q, ram_wen_d;
  logic                ram_ren_q, ram_ren_d;

  size_e               cpu_size_c;
  logic [1:0]          cpu_off_c;
  logic                cpu_bad_c;
  logic                dbg_win_c;
  logic [N_LANES-1:0]  st_wen_c;
  logic [NB_DATA-1:0]  st_din_c;
  logic [NB_DATA-1:0]  ld_rdata_c;

  assign cpu_size_c = size_e'(bus.i_cpu_size);
  assign cpu_off_c  = bus.i_cpu_addr[1:0];
  assign cpu_bad_c  = access_err(cpu_size_c, cpu_off_c);
  // CPU has priority unless debug has waited through the maximum CPU grants.
  assign dbg_win_c  = bus.i_dbg_req &&
                      (!bus.i_cpu_req || (starve_q == NB_STARVE'(DBG_STARVE_MAX)));

  dmem_lane_align u_lane_align (
    .i_st_size  (cpu_size_c),
    .i_st_off   (cpu_off_c),
    .i_st_wdata (bus.i_cpu_wdata),
    .o_wen_c    (st_wen_c),
    .o_din_c    (st_din_c),
    .i_ld_size  (req_q.size),
    .i_ld_off   (req_q.off),
    .i_ld_uns   (req_q.uns),
    .i_ld_dout  (bus.i_ram_dout),
    .o_rdata_c  (ld_rdata_c)
  );

  // Next-state, arbitration and registered-output values.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    req_d       = req_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    cpu_err_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    dbg_ack_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_wen_d   = '0;
    ram_ren_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.i_dbg_req) starve_d = '0;
        if (dbg_win_c) begin
          starve_d   = '0;
          req_d.dbg  = 1'b1;
          req_d.we   = bus.i_dbg_we;
          req_d.size = SIZE_W;
          req_d.uns  = 1'b0;
          req_d.off  = 2'b00;
          ram_addr_d = bus.i_dbg_addr;
          ram_din_d  = bus.i_dbg_wdata;
          ram_wen_d  = bus.i_dbg_we ? '1 : '0;
          ram_ren_d  = !bus.i_dbg_we;
          state_d    = ST_ACCESS;
        end else if (bus.i_cpu_req) begin
          if (bus.i_dbg_req) starve_d = NB_STARVE'(starve_q + 1'b1);
          req_d.dbg  = 1'b0;
          req_d.we   = bus.i_cpu_we;
          req_d.size = cpu_size_c;
          req_d.uns  = bus.i_cpu_unsigned;
          req_d.off  = cpu_off_c;
          if (cpu_bad_c) begin
            cpu_rdata_d = '0;
            cpu_ack_d   = 1'b1;
            cpu_err_d   = 1'b1;
            state_d     = ST_RESP;
          end else begin
            ram_addr_d = bus.i_cpu_addr[NB_BADDR-1:2];
            ram_din_d  = st_din_c;
            ram_wen_d  = bus.i_cpu_we ? st_wen_c : '0;
            ram_ren_d  = !bus.i_cpu_we;
            state_d    = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (req_q.we) begin
          cpu_ack_d = !req_q.dbg;
          dbg_ack_d = req_q.dbg;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (req_q.dbg) begin
          dbg_rdata_d = bus.i_ram_dout;
          dbg_ack_d   = 1'b1;
        end else begin
          cpu_rdata_d = ld_rdata_c;
          cpu_ack_d   = 1'b1;
        end
        state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, arbitration and output registers; reset aborts any access.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      req_q       <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      dbg_rdata_q <= '0;
      dbg_ack_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_wen_q   <= '0;
      ram_ren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      req_q       <= req_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_ack_q   <= dbg_ack_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_wen_q   <= ram_wen_d;
      ram_ren_q   <= ram_ren_d;
    end
  end

  assign bus.o_cpu_rdata = cpu_rdata_q;
  assign bus.o_cpu_ack   = cpu_ack_q;
  assign bus.o_cpu_err   = cpu_err_q;
  assign bus.o_dbg_rdata = dbg_rdata_q;
  assign bus.o_dbg_ack   = dbg_ack_q;
  assign bus.o_ram_waddr = ram_addr_q;
  assign bus.o_ram_raddr = ram_addr_q;
  assign bus.o_ram_din   = ram_din_q;
  assign bus.o_ram_wen   = ram_wen_q;
  assign bus.o_ram_ren   = ram_ren_q;

endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench for dmem_controller with a byte-enable BRAM model.
module tb_dmem_controller;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_controller_if bus ();

  dmem_controller dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  // BRAM model: byte writes, registered read; bench preload port.
  logic [31:0]         mem [RAM_DEPTH];
  logic [31:0]         ram_dout = '0;
  logic                pre_we = 1'b0;
  logic [NB_WADDR-1:0] pre_addr = '0;
  logic [31:0]         pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    for (int i = 0; i < 4; i++)
      if (bus.o_ram_wen[i]) mem[bus.o_ram_waddr][8*i +: 8] <= bus.o_ram_din[8*i +: 8];
    if (bus.o_ram_ren) ram_dout <= mem[bus.o_ram_raddr];
  end
  assign bus.i_ram_dout = ram_dout;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [NB_WADDR-1:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  // One access on either port; returns ack latency (0 = timeout) and BRAM activity seen.
  task automatic do_op(input bit dbg, input bit we, input logic [1:0] size, input bit uns,
                       input logic [NB_BADDR-1:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output int wen_cyc, output int ren_cyc, output logic [3:0] wen_seen);
    lat = 0; wen_cyc = 0; ren_cyc = 0; wen_seen = '0; rdata = '0; err = 1'b0;
    if (dbg) begin
      bus.i_dbg_we = we; bus.i_dbg_addr = addr[NB_BADDR-1:2]; bus.i_dbg_wdata = wdata;
      bus.i_dbg_req = 1'b1;
    end else begin
      bus.i_cpu_we = we; bus.i_cpu_size = size; bus.i_cpu_unsigned = uns;
      bus.i_cpu_addr = addr; bus.i_cpu_wdata = wdata;
      bus.i_cpu_req = 1'b1;
    end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.o_ram_wen != 4'b0) begin wen_cyc++; wen_seen = bus.o_ram_wen; end
      if (bus.o_ram_ren) ren_cyc++;
      if (dbg ? bus.o_dbg_ack : bus.o_cpu_ack) begin
        lat   = n;
        rdata = dbg ? bus.o_dbg_rdata : bus.o_cpu_rdata;
        err   = dbg ? 1'b0 : bus.o_cpu_err;
        break;
      end
    end
    bus.i_cpu_req = 1'b0;
    bus.i_dbg_req = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, wc, rc, nacks, tmo;
  logic [3:0]  ws;
  logic        seq [10];

  initial begin
    bus.i_cpu_req = 0; bus.i_cpu_we = 0; bus.i_cpu_size = 0; bus.i_cpu_unsigned = 0;
    bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
    bus.i_dbg_req = 0; bus.i_dbg_we = 0; bus.i_dbg_addr = '0; bus.i_dbg_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_flags", 32'({bus.o_cpu_ack, bus.o_cpu_err, bus.o_dbg_ack, bus.o_ram_ren}), 32'h0);
    check_eq("rst_wen", 32'(bus.o_ram_wen), 32'h0);
    check_eq("rst_cpu_rdata", bus.o_cpu_rdata, 32'h0);
    check_eq("rst_dbg_rdata", bus.o_dbg_rdata, 32'h0);
    check_eq("rst_addr", 32'({bus.o_ram_waddr, bus.o_ram_raddr}), 32'h0);
    check_eq("rst_din", bus.o_ram_din, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store then load
    do_op(0, 1, 2'b10, 0, 11'h010, 32'hDEADBEEF, rd, er, lat, wc, rc, ws);
    check_eq("sw_lat", 32'(lat), 32'd2);
    check_eq("sw_wen_cycles", 32'(wc), 32'd1);
    check_eq("sw_wen", 32'(ws), 32'hF);
    check_eq("sw_err", 32'(er), 32'h0);
    check_eq("sw_mem", mem[4], 32'hDEADBEEF);
    do_op(0, 0, 2'b10, 0, 11'h010, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("lw_lat", 32'(lat), 32'd3);
    check_eq("lw_rdata", rd, 32'hDEADBEEF);
    check_eq("lw_ren_cycles", 32'(rc), 32'd1);

    // Byte/half extension on 0x80FF7F01 at 0x20
    preload(9'd8, 32'h80FF7F01);
    do_op(0, 0, 2'b00, 0, 11'h023, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("lb_23", rd, 32'hFFFFFF80);
    do_op(0, 0, 2'b00, 1, 11'h023, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("lbu_23", rd, 32'h00000080);
    do_op(0, 0, 2'b01, 0, 11'h022, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("lh_22", rd, 32'hFFFF80FF);
    do_op(0, 0, 2'b01, 1, 11'h020, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("lhu_20", rd, 32'h00007F01);
    do_op(0, 1, 2'b00, 0, 11'h021, 32'h000000AA, rd, er, lat, wc, rc, ws);
    check_eq("sb_wen", 32'(ws), 32'h2);
    do_op(0, 0, 2'b10, 0, 11'h020, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("sb_readback", rd, 32'h80FFAA01);

    // Misalignment and illegal size
    do_op(0, 0, 2'b10, 0, 11'h012, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("lw12_lat", 32'(lat), 32'd1);
    check_eq("lw12_err", 32'(er), 32'h1);
    check_eq("lw12_rdata", rd, 32'h0);
    check_eq("lw12_bram", 32'(wc + rc), 32'd0);
    do_op(0, 1, 2'b01, 0, 11'h013, 32'h0000BEEF, rd, er, lat, wc, rc, ws);
    check_eq("sh13_lat", 32'(lat), 32'd1);
    check_eq("sh13_err", 32'(er), 32'h1);
    check_eq("sh13_bram", 32'(wc + rc), 32'd0);
    do_op(0, 0, 2'b11, 0, 11'h010, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("sz11_lat", 32'(lat), 32'd1);
    check_eq("sz11_err", 32'(er), 32'h1);
    check_eq("sz11_rdata", rd, 32'h0);
    check_eq("sz11_bram", 32'(wc + rc), 32'd0);
    check_eq("misalign_mem", mem[4], 32'hDEADBEEF);

    // Debug path
    do_op(1, 1, 2'b10, 0, 11'h014, 32'h12345678, rd, er, lat, wc, rc, ws);
    check_eq("dbg_w_lat", 32'(lat), 32'd2);
    check_eq("dbg_w_wen", 32'(ws), 32'hF);
    do_op(0, 0, 2'b10, 0, 11'h014, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("dbg_cpu_lw", rd, 32'h12345678);
    do_op(1, 0, 2'b10, 0, 11'h014, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("dbg_r_lat", 32'(lat), 32'd3);
    check_eq("dbg_r_rdata", rd, 32'h12345678);

    // Starvation guard: both held continuously
    bus.i_cpu_we = 0; bus.i_cpu_size = 2'b10; bus.i_cpu_unsigned = 0; bus.i_cpu_addr = 11'h010;
    bus.i_dbg_we = 0; bus.i_dbg_addr = 9'd5;
    bus.i_cpu_req = 1; bus.i_dbg_req = 1;
    nacks = 0;
    for (int i = 0; i < 10; i++) seq[i] = 1'b0;
    for (int n = 0; n < 200 && nacks < 10; n++) begin
      @(posedge clk); #1;
      if (bus.o_cpu_ack) begin seq[nacks] = 1'b0; nacks++; end
      else if (bus.o_dbg_ack) begin
        check_eq("starve_dbg_rdata", bus.o_dbg_rdata, 32'h12345678);
        seq[nacks] = 1'b1; nacks++;
      end
    end
    bus.i_cpu_req = 0; bus.i_dbg_req = 0;
    @(posedge clk); #1;
    check_eq("starve_nacks", 32'(nacks), 32'd10);
    for (int i = 0; i < 10; i++)
      check_eq($sformatf("starve_seq%0d", i), 32'(seq[i]), 32'((i % 5) == 4));

    // Reset abort during ACCESS of a write
    bus.i_cpu_we = 1; bus.i_cpu_size = 2'b10; bus.i_cpu_addr = 11'h010;
    bus.i_cpu_wdata = 32'hCAFEF00D; bus.i_cpu_req = 1;
    @(posedge clk); #1;
    check_eq("abort_wen_pre", 32'(bus.o_ram_wen), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_wen", 32'(bus.o_ram_wen), 32'h0);
    check_eq("abort_flags", 32'({bus.o_cpu_ack, bus.o_cpu_err, bus.o_dbg_ack, bus.o_ram_ren}), 32'h0);
    check_eq("abort_rdata", bus.o_cpu_rdata, 32'h0);
    check_eq("abort_din", bus.o_ram_din, 32'h0);
    bus.i_cpu_req = 0;
    tmo = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.o_cpu_ack) tmo++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.o_cpu_ack || bus.o_dbg_ack) tmo++;
    end
    check_eq("abort_no_ack", 32'(tmo), 32'd0);
    check_eq("abort_mem", mem[4], 32'hDEADBEEF);
    do_op(0, 0, 2'b10, 0, 11'h010, 32'h0, rd, er, lat, wc, rc, ws);
    check_eq("abort_lw_lat", 32'(lat), 32'd3);
    check_eq("abort_lw_rdata", rd, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_controller.md
# dmem_controller

Sequencing and arbitration front-end for the data-memory `byte_enable_bram` in the MIPS datapath. Two requesters share the single BRAM: the pipeline MEM stage (CPU port, byte/half/word loads and stores) and the debug unit (word-only access). The block converts each granted CPU access into BRAM byte-enables and lane-replicated write data, and returns sign- or zero-extended load data. It also flags misaligned accesses and keeps the debug port from starving under continuous CPU traffic.

## Interface
- `NB_DATA`, 32: data width; fixed at 4 lanes of 8 bits.
- `RAM_DEPTH`, 512: BRAM word count.
- `NB_WADDR`, clogb2(RAM_DEPTH-1): word-address width.
- `NB_BADDR`, NB_WADDR+2: CPU byte-address width.
- `DBG_STARVE_MAX`, 4: maximum consecutive CPU grants while a debug request is pending.
- One clock; reset is asynchronous and active-low. The clock port is `i_clk` and the reset port is `i_rst`.
- `i_clk`  in  1  clock
- `i_rst`  in  1  asynchronous active-low reset
- `i_cpu_req`  in  1  CPU request; level signal, held with its fields until `o_cpu_ack`
- `i_cpu_we`  in  1  1 = store, 0 = load
- `i_cpu_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `i_cpu_unsigned`  in  1  load zero-extends (LBU/LHU)
- `i_cpu_addr`  in  NB_BADDR  byte address
- `i_cpu_wdata`  in  32  store data, right-justified
- `o_cpu_rdata`  out  32  extended load data; valid while `o_cpu_ack` is high
- `o_cpu_ack`  out  1  one-cycle completion pulse
- `o_cpu_err`  out  1  misaligned or illegal size; valid with ack
- `i_dbg_req`, `i_dbg_we`  in  1 each  debug request and write flag; same holding rule as the CPU port
- `i_dbg_addr`  in  NB_WADDR  word address
- `i_dbg_wdata`  in  32  debug write word
- `o_dbg_rdata`  out  32  debug read word
- `o_dbg_ack`  out  1  one-cycle completion pulse
- `o_ram_waddr`, `o_ram_raddr`  out  NB_WADDR  BRAM addresses
- `o_ram_din`  out  32  BRAM write data
- `o_ram_wen`  out  4  byte-write enables; bit i covers bits [8i+7:8i]
- `o_ram_ren`  out  1  BRAM read enable
- `i_ram_dout`  in  32  BRAM registered read data, valid one cycle after `o_ram_ren`

## Operation
- Lanes are little-endian: byte offset `addr[1:0]`=k maps to lane k.
- FSM states: IDLE, ACCESS, DATA, RESP.
  - IDLE: arbitrate, latch the granted request, go to ACCESS. If the CPU request is misaligned or illegal, skip the BRAM and go to RESP with err=1.
  - ACCESS: drive the BRAM for one cycle. A write goes to RESP. A read goes to DATA.
  - DATA: `i_ram_dout` is valid. Align and extend it, then register it into the granted port's rdata.
  - RESP: the granted port's ack is high for one cycle, then the FSM returns to IDLE.
- Arbitration:
  - The CPU has priority.
  - Counter `starve` increments on each CPU grant taken while `i_dbg_req` is high.
  - If `starve == DBG_STARVE_MAX` and `i_dbg_req` is high, debug wins.
  - `starve` clears on any debug grant, and in IDLE whenever `i_dbg_req` is low.
- Store formatting:
  - SB: wen = 1<<k; din = {4{wdata[7:0]}}.
  - SH: wen = k[1] ? 1100 : 0011; din = {2{wdata[15:0]}}.
  - SW: wen = 1111.
  - Debug write: wen = 1111.
- Load formatting: shift `i_ram_dout` right by 8k, then:
  - byte: extend bit 7.
  - half: extend bit 15.
  - zero-extend instead when `i_cpu_unsigned` is set.
  - Debug read returns the raw word.
- Error conditions:
  - Half access with k[0]=1.
  - Word access with k≠0.
  - Size 11.
  - On error: no BRAM activity, rdata=0, and err is asserted together with ack.
- BRAM addressing: word address = `addr[NB_BADDR-1:2]`. Both BRAM addresses carry the latched address.
- Outside ACCESS, `o_ram_wen`=0 and `o_ram_ren`=0.

## Timing
- Reset values: state IDLE, `starve`=0, and every output 0 (acks, err, rdata, wen, ren, addresses, din).
- Reset mid-operation aborts the access.
  - No ack is issued.
  - `o_ram_wen` drops asynchronously, so no write lands unless a clock edge occurred in ACCESS before reset asserted.
- Let cycle 0 be the IDLE cycle in which `req` is sampled.
  - Read: ACCESS in cycle 1, DATA in cycle 2, ack in cycle 3.
  - Write: ACCESS in cycle 1, ack in cycle 2.
  - Error: ack and err in cycle 1.
- All port outputs are registered. There are no combinational paths from req to ack.
- The next request can be sampled in the cycle after RESP. Peak throughput is one read per 4 cycles or one write per 3 cycles.
- If `req` is still high in the IDLE cycle after ack, it is taken as a new request.
- If both requests arrive in the same cycle, the rule above applies. The loser waits with `req` held.

## Structure
- Package `dmem_pkg`:
  - Size encodings (SIZE_B/H/W).
  - FSM state encoding.
  - Lane count and lane width constants.
- Sub-module `dmem_lane_align`: combinational store formatter (wen/din) and load extractor/extender. This keeps the FSM and arbiter separate from the lane logic.

## Test plan
- **Store then load.** SW 0xDEADBEEF to addr 0x10, then LW 0x10 → write ack in cycle 2, read ack in cycle 3, rdata 0xDEADBEEF, `o_ram_wen`=1111 for exactly one cycle.
- **Byte/half extension.** With word 0x80FF7F01 at 0x20:
  - LB 0x23 → 0xFFFFFF80.
  - LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF80FF.
  - LHU 0x20 → 0x00007F01.
  - SB 0xAA to 0x21 → wen=0010, and the word reads back as 0x80FFAA01.
- **Misalignment.** LW 0x12, SH 0x13, and size 11 each give ack+err in cycle 1, rdata 0, and no `o_ram_ren`/`o_ram_wen` pulse; the memory contents are unchanged.
- **Starvation guard.** Hold `i_cpu_req` and `i_dbg_req` high continuously → exactly 4 CPU acks, then 1 debug ack, repeating. Simultaneous first requests go to the CPU.
- **Debug path.** Debug write 0x12345678 to word 5, then CPU LW 0x14 → 0x12345678. Debug read of word 5 returns the raw word.
- **Reset abort.** Assert `i_rst` low during ACCESS of a write, before the clock edge → all outputs go to 0 immediately, no ack appears, a later read shows old data, and the FSM resumes in IDLE after release.
